cp0_intc: RTL

Parametrised successor to the CP0 coprocessor of the multi-cycle MIPS core. It holds SR, Cause, EPC and PrID, and adds a configurable number of hardware interrupt lines, a per-line level/edge mode with sticky write-1-to-clear pending bits, and a fixed-priority interrupt-ID output. It sits beside the controller: it raises `IntReq` toward the controller, latches the PC on `EXLSet`, and feeds `DOut` into the DR mux for `mfc0`.

---
 rtl/cp0_pkg.sv | 20 ++
 rtl/cp0_int_line.sv | 41 ++++
 rtl/cp0_intc.sv | 105 ++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// CP0 register numbers and bit positions shared by the interrupt controller files.
// No logic, no latency; constants only.
// No flow control.
package cp0_pkg;

   typedef logic [4:0] cp0_sel_t;

   localparam cp0_sel_t CP0_SEL_SR    = 5'd12;
   localparam cp0_sel_t CP0_SEL_CAUSE = 5'd13;
   localparam cp0_sel_t CP0_SEL_EPC   = 5'd14;
   localparam cp0_sel_t CP0_SEL_PRID  = 5'd15;
   localparam cp0_sel_t CP0_SEL_EDGE  = 5'd16;

   localparam int SR_IE   = 0;
   localparam int SR_EXL  = 1;
   localparam int IM_BASE = 10;

   localparam logic [4:0] EXC_INT = 5'd0;

endpackage

// File: rtl/cp0_int_line.sv
// One interrupt line: optional 2-flop synchroniser (CP0_INT_SYNC_EN), edge detect, sticky IP.
// IP follows the sampled line 1 edge later (3 edges with the synchroniser).
// No backpressure; W1C clear loses to a coincident new edge.
module cp0_int_line (
   input  logic clk,
   input  logic rst,
   input  logic hwint,
   input  logic edge_mode,
   input  logic w1c,
   output logic ip
);

   logic s;
   logic s_q;

`ifdef CP0_INT_SYNC_EN
   logic [1:0] sync;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync <= 2'b00;
      else      sync <= {sync[0], hwint};
   end

   assign s = sync[1];
`else
   assign s = hwint;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_q <= 1'b0;
         ip  <= 1'b0;
      end else begin
         s_q <= s;
         // set term is OR'd last so a new edge survives a same-cycle clear
         if (edge_mode) ip <= (ip & ~w1c) | (s & ~s_q);
         else           ip <= s;
      end
   end

endmodule

// File: rtl/cp0_intc.sv
// CP0 with SR/Cause/EPC/PrID/EdgeMode, per-line interrupt capture and fixed-priority IntId.
// IntReq rises 1 edge after a line is sampled high (3 with CP0_INT_SYNC_EN); DOut is combinational.
// No backpressure; EXLSet beats EXLClr and same-cycle writes to EPC or SR.EXL.
module cp0_intc
   import cp0_pkg::*;
#(
   parameter int          INT_CNT = 6,
   parameter logic [31:0] PRID    = 32'h0000_4D50
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [29:0]                  PC,
   input  logic [31:0]                  Din,
   input  logic [4:0]                   Sel,
   input  logic                         Wen,
   input  logic                         EXLSet,
   input  logic                         EXLClr,
   input  logic [INT_CNT:1]             HWInt,
   output logic                         IntReq,
   output logic [$clog2(INT_CNT+1)-1:0] IntId,
   output logic [29:0]                  EPC,
   output logic [31:0]                  DOut
);

   localparam int IDW = $clog2(INT_CNT+1);

   logic               ie;
   logic               exl;
   logic [INT_CNT:1]   im;
   logic [INT_CNT:1]   edge_mode;
   logic [INT_CNT:1]   ip;
   logic [INT_CNT:1]   w1c;
   logic [INT_CNT:1]   elig;
   logic               sr_wr, cause_wr, epc_wr, edge_wr;

   assign sr_wr    = Wen && (Sel == CP0_SEL_SR);
   assign cause_wr = Wen && (Sel == CP0_SEL_CAUSE);
   assign epc_wr   = Wen && (Sel == CP0_SEL_EPC);
   assign edge_wr  = Wen && (Sel == CP0_SEL_EDGE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ie        <= 1'b0;
         exl       <= 1'b0;
         im        <= '0;
         edge_mode <= '0;
         EPC       <= '0;
      end else begin
         if (sr_wr) begin
            ie <= Din[SR_IE];
            im <= Din[IM_BASE +: INT_CNT];
         end
         if (EXLSet)      exl <= 1'b1;
         else if (sr_wr)  exl <= Din[SR_EXL];
         else if (EXLClr) exl <= 1'b0;
         if (EXLSet)      EPC <= PC;
         else if (epc_wr) EPC <= Din[31:2];
         if (edge_wr) edge_mode <= Din[INT_CNT-1:0];
      end
   end

   assign w1c = {INT_CNT{cause_wr}} & Din[IM_BASE +: INT_CNT];

   for (genvar gi = 1; gi <= INT_CNT; gi++) begin : g_line
      cp0_int_line u_line (
         .clk       (clk),
         .rst       (rst),
         .hwint     (HWInt[gi]),
         .edge_mode (edge_mode[gi]),
         .w1c       (w1c[gi]),
         .ip        (ip[gi])
      );
   end

   assign elig   = ip & im;
   assign IntReq = (|elig) & ie & ~exl;

   // scan downwards so the lowest-numbered eligible line wins
   always_comb begin
      IntId = '0;
      for (int i = INT_CNT; i >= 1; i--) begin
         if (elig[i]) IntId = IDW'(i);
      end
   end

   always_comb begin
      DOut = '0;
      case (Sel)
         CP0_SEL_SR: begin
            DOut[SR_IE]               = ie;
            DOut[SR_EXL]              = exl;
            DOut[IM_BASE +: INT_CNT]  = im;
         end
         CP0_SEL_CAUSE: begin
            DOut[IM_BASE +: INT_CNT]  = ip;
            DOut[6:2]                 = EXC_INT;
         end
         CP0_SEL_EPC:  DOut = {EPC, 2'b00};
         CP0_SEL_PRID: DOut = PRID;
         CP0_SEL_EDGE: DOut[INT_CNT-1:0] = edge_mode;
         default:      DOut = '0;
      endcase
   end

endmodule
